// File: rtl/ntt_stream_reorder_pkg.sv
// Shared types, default geometry and the input-beat to bank-row mapping
// for the NTT stream reorder buffer.
package ntt_io_pkg;

    localparam int DEF_LANES  = 8;
    localparam int DEF_WORD_W = 16;
    localparam int DEF_N      = 1024;

    // Life cycle of one ping-pong bank.
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_st_e;

    // Row that input beat k lands in. Half-interleaved input alternates
    // low-half and high-half beats, so odd beats go to the upper half.
    function automatic int unsigned row_map(input int unsigned k,
                                            input logic        ilv,
                                            input int unsigned beats);
        int unsigned row;
        if (ilv) begin
            row = (k >> 1) + (k[0] ? (beats >> 1) : 32'd0);
        end else begin
            row = k;
        end
        return row;
    endfunction

endpackage

// File: rtl/ntt_stream_reorder_if.sv
// Load-side and switch-side valid/ready streams of the reorder buffer.
interface ntt_stream_reorder_if #(
    parameter int LANES  = ntt_io_pkg::DEF_LANES,
    parameter int WORD_W = ntt_io_pkg::DEF_WORD_W
);
    logic                      ld_vld;
    logic                      ld_rdy;
    logic [LANES*WORD_W-1:0]   ld_dat;
    logic                      sw_vld;
    logic                      sw_rdy;
    logic [LANES*WORD_W-1:0]   sw_dat;
    logic                      sw_lst;

    // Producer of input beats and consumer of output beats.
    modport master (
        output ld_vld, ld_dat, sw_rdy,
        input  ld_rdy, sw_vld, sw_dat, sw_lst
    );

    // The reorder buffer itself.
    modport slave (
        input  ld_vld, ld_dat, sw_rdy,
        output ld_rdy, sw_vld, sw_dat, sw_lst
    );
endinterface

// File: rtl/ntt_stream_reorder_bank_ram.sv
// Simple dual-port RAM holding both banks; bank index is the address MSB.
// One write port, one registered read port (one-cycle read latency).
module ntt_bank_ram #(
    parameter int DW = 128,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Write port and registered read port; read data holds when not reading.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ntt_stream_reorder.sv
// Ping-pong reorder buffer: loads polynomials in natural or half-interleaved
// beat order into one bank while the other drains in natural row order
// through a 2-entry output queue that hides the RAM read latency.
module ntt_stream_reorder
    import ntt_io_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int WORD_W = DEF_WORD_W,
    parameter int N      = DEF_N
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr,
    input  logic                   ilv,
    ntt_stream_reorder_if.slave    io,
    output logic                   busy
);

    localparam int BEATS = N / LANES;
    localparam int AW    = $clog2(BEATS);
    localparam int DW    = LANES * WORD_W;
    localparam logic [AW-1:0] LAST_ROW = AW'(BEATS - 1);
    localparam logic [AW-1:0] ROW0     = {AW{1'b0}};
    localparam logic [AW-1:0] ROW_INC  = {{(AW-1){1'b0}}, 1'b1};

    bank_st_e          bank_st_q [2];
    bank_st_e          bank_st_d [2];
    logic [1:0]        bank_ilv_q, bank_ilv_d;
    logic              wsel_q, wsel_d;
    logic              rsel_q, rsel_d;
    logic [AW-1:0]     wcnt_q, wcnt_d;
    logic [AW-1:0]     rcnt_q, rcnt_d;
    logic              ld_rdy_q, ld_rdy_d;
    logic              busy_q, busy_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_lst_q, rd_lst_d;
    logic              h_vld_q, h_vld_d, t_vld_q, t_vld_d;
    logic              h_lst_q, h_lst_d, t_lst_q, t_lst_d;
    logic [DW-1:0]     h_dat_q, h_dat_d, t_dat_q, t_dat_d;

    logic              wr_acc_s;
    logic              ilv_eff_s;
    logic [AW-1:0]     wrow_s;
    logic              pop_s;
    logic [1:0]        in_flight_s;
    logic              rd_ok_s;
    logic [DW-1:0]     rdata_s;

    // The ilv sampled on a bank's first beat governs the whole polynomial.
    assign wr_acc_s    = io.ld_vld & ld_rdy_q;
    assign ilv_eff_s   = (wcnt_q == ROW0) ? ilv : bank_ilv_q[wsel_q];
    assign wrow_s      = AW'(row_map(32'(wcnt_q), ilv_eff_s, unsigned'(BEATS)));
    assign pop_s       = h_vld_q & io.sw_rdy;
    // Entries held or in flight after this cycle's pop; a read may issue
    // only if its data will still find a free queue slot.
    assign in_flight_s = {1'b0, h_vld_q} + {1'b0, t_vld_q} + {1'b0, rd_pend_q} - {1'b0, pop_s};
    assign rd_ok_s     = ((bank_st_q[rsel_q] == FULL) || (bank_st_q[rsel_q] == DRAINING)) &&
                         (in_flight_s < 2'd2);

    ntt_bank_ram #(.DW(DW), .AW(AW + 1)) u_ram (
        .clk     (clk),
        .we_i    (wr_acc_s & ~clr),
        .waddr_i ({wsel_q, wrow_s}),
        .wdata_i (io.ld_dat),
        .re_i    (rd_ok_s & ~clr),
        .raddr_i ({rsel_q, rcnt_q}),
        .rdata_o (rdata_s)
    );

    // Next-state for bank FSMs, write/read pointers and the output queue.
    always_comb begin
        bank_st_d  = bank_st_q;
        bank_ilv_d = bank_ilv_q;
        wsel_d     = wsel_q;
        rsel_d     = rsel_q;
        wcnt_d     = wcnt_q;
        rcnt_d     = rcnt_q;
        rd_pend_d  = 1'b0;
        rd_lst_d   = 1'b0;
        h_vld_d    = h_vld_q;
        h_dat_d    = h_dat_q;
        h_lst_d    = h_lst_q;
        t_vld_d    = t_vld_q;
        t_dat_d    = t_dat_q;
        t_lst_d    = t_lst_q;
        ld_rdy_d   = 1'b0;
        busy_d     = 1'b0;

        if (clr) begin
            bank_st_d[0] = EMPTY;
            bank_st_d[1] = EMPTY;
            bank_ilv_d   = 2'b00;
            wsel_d       = 1'b0;
            rsel_d       = 1'b0;
            wcnt_d       = ROW0;
            rcnt_d       = ROW0;
            h_vld_d      = 1'b0;
            h_dat_d      = {DW{1'b0}};
            h_lst_d      = 1'b0;
            t_vld_d      = 1'b0;
            t_dat_d      = {DW{1'b0}};
            t_lst_d      = 1'b0;
        end else begin
            // Write side: first beat opens the bank, last beat seals it.
            if (wr_acc_s) begin
                if (wcnt_q == ROW0) begin
                    bank_st_d[wsel_q]  = FILLING;
                    bank_ilv_d[wsel_q] = ilv;
                end else begin
                    bank_ilv_d = bank_ilv_q;
                end
                if (wcnt_q == LAST_ROW) begin
                    bank_st_d[wsel_q] = FULL;
                    wsel_d            = ~wsel_q;
                    wcnt_d            = ROW0;
                end else begin
                    wcnt_d = wcnt_q + ROW_INC;
                end
            end else begin
                wcnt_d = wcnt_q;
            end

            // Read side: the final row frees the bank as it is issued.
            if (rd_ok_s) begin
                rd_pend_d = 1'b1;
                rd_lst_d  = (rcnt_q == LAST_ROW);
                if (rcnt_q == LAST_ROW) begin
                    bank_st_d[rsel_q] = EMPTY;
                    rsel_d            = ~rsel_q;
                    rcnt_d            = ROW0;
                end else begin
                    bank_st_d[rsel_q] = DRAINING;
                    rcnt_d            = rcnt_q + ROW_INC;
                end
            end else begin
                rcnt_d = rcnt_q;
            end

            // Queue: pop shifts tail to head, RAM data fills first free slot.
            if (pop_s) begin
                h_vld_d = t_vld_q;
                h_dat_d = t_dat_q;
                h_lst_d = t_lst_q;
                t_vld_d = 1'b0;
                t_dat_d = {DW{1'b0}};
                t_lst_d = 1'b0;
            end else begin
                h_vld_d = h_vld_q;
            end
            if (rd_pend_q) begin
                if (!h_vld_d) begin
                    h_vld_d = 1'b1;
                    h_dat_d = rdata_s;
                    h_lst_d = rd_lst_q;
                end else begin
                    t_vld_d = 1'b1;
                    t_dat_d = rdata_s;
                    t_lst_d = rd_lst_q;
                end
            end else begin
                t_vld_d = t_vld_d;
            end
        end

        ld_rdy_d = (bank_st_d[wsel_d] == EMPTY) || (bank_st_d[wsel_d] == FILLING);
        busy_d   = (bank_st_d[0] != EMPTY) || (bank_st_d[1] != EMPTY) ||
                   h_vld_d || t_vld_d || rd_pend_d;
    end

    // State registers; rstn is an asynchronous active-high reset.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            bank_st_q[0] <= EMPTY;
            bank_st_q[1] <= EMPTY;
            bank_ilv_q   <= 2'b00;
            wsel_q       <= 1'b0;
            rsel_q       <= 1'b0;
            wcnt_q       <= ROW0;
            rcnt_q       <= ROW0;
            ld_rdy_q     <= 1'b0;
            busy_q       <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_lst_q     <= 1'b0;
            h_vld_q      <= 1'b0;
            h_dat_q      <= {DW{1'b0}};
            h_lst_q      <= 1'b0;
            t_vld_q      <= 1'b0;
            t_dat_q      <= {DW{1'b0}};
            t_lst_q      <= 1'b0;
        end else begin
            bank_st_q    <= bank_st_d;
            bank_ilv_q   <= bank_ilv_d;
            wsel_q       <= wsel_d;
            rsel_q       <= rsel_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            ld_rdy_q     <= ld_rdy_d;
            busy_q       <= busy_d;
            rd_pend_q    <= rd_pend_d;
            rd_lst_q     <= rd_lst_d;
            h_vld_q      <= h_vld_d;
            h_dat_q      <= h_dat_d;
            h_lst_q      <= h_lst_d;
            t_vld_q      <= t_vld_d;
            t_dat_q      <= t_dat_d;
            t_lst_q      <= t_lst_d;
        end
    end

    assign io.ld_rdy = ld_rdy_q;
    assign io.sw_vld = h_vld_q;
    assign io.sw_dat = h_dat_q;
    assign io.sw_lst = h_lst_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ntt_stream_reorder.sv
// Directed bench for ntt_stream_reorder: loads polynomials in both orders,
// checks output order, sw_lst, latency, throughput, backpressure, rstn and clr.
module tb_ntt_stream_reorder;

    localparam int LANES  = 8;
    localparam int WORD_W = 16;
    localparam int N      = 1024;
    localparam int BEATS  = N / LANES;
    localparam int DW     = LANES * WORD_W;

    logic clk = 1'b0;
    logic rstn, clr, ilv, busy;

    ntt_stream_reorder_if #(.LANES(LANES), .WORD_W(WORD_W)) io ();

    ntt_stream_reorder #(.LANES(LANES), .WORD_W(WORD_W), .N(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .ilv  (ilv),
        .io   (io),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] in_q[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_lst_q[$];
    int   cyc = 0;
    int   acc_cnt = 0;
    int   first_vld_cyc = -1;
    int   last_acc_cyc = -1;
    int   out_first = -1;
    int   out_last = -1;
    int   n_out = 0;
    logic ilv_base = 1'b0;
    logic ilv_glitch = 1'b0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_dat;
    logic prev_lst;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s obs=%0h req=%0h", tag, obs, req);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s obs=%b req=%b", tag, obs, req);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s obs=%0d req=%0d", tag, obs, req);
        end
    endtask

    // Beat made of 8 consecutive coefficients base+w0 .. base+w0+7, lane 0 low.
    function automatic logic [DW-1:0] mk(input int base, input int w0);
        logic [DW-1:0] r;
        for (int j = 0; j < LANES; j++) r[j*WORD_W +: WORD_W] = 16'(base + w0 + j);
        return r;
    endfunction

    task automatic push_poly(input int base, input logic order_ilv);
        for (int k = 0; k < BEATS; k++) begin
            if (!order_ilv)      in_q.push_back(mk(base, k * 8));
            else if (k % 2 == 0) in_q.push_back(mk(base, (k / 2) * 8));
            else                 in_q.push_back(mk(base, N / 2 + (k / 2) * 8));
        end
        for (int m = 0; m < BEATS; m++) begin
            exp_q.push_back(mk(base, m * 8));
            exp_lst_q.push_back(m == BEATS - 1);
        end
    endtask

    // One clock: drive, check the beat about to move, advance past the edge.
    task automatic step(input logic rdy);
        logic ld_go, sw_go;
        io.sw_rdy = rdy;
        io.ld_vld = (in_q.size() > 0);
        io.ld_dat = (in_q.size() > 0) ? in_q[0] : {DW{1'b0}};
        ilv = (ilv_glitch && (acc_cnt % BEATS != 0)) ? 1'($urandom) : ilv_base;
        ld_go = io.ld_vld && io.ld_rdy;
        sw_go = io.sw_vld && rdy;
        if (prev_stall) begin
            chk_b("stall_vld", io.sw_vld, 1'b1);
            chk("stall_dat", io.sw_dat, prev_dat);
            chk_b("stall_lst", io.sw_lst, prev_lst);
        end
        if (first_vld_cyc < 0 && io.sw_vld) first_vld_cyc = cyc;
        if (sw_go) begin
            chk_b("beat_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                chk("out_dat", io.sw_dat, exp_q.pop_front());
                chk_b("out_lst", io.sw_lst, exp_lst_q.pop_front());
            end
            if (n_out == 0) out_first = cyc;
            out_last = cyc;
            n_out++;
        end
        prev_stall = io.sw_vld && !rdy;
        prev_dat   = io.sw_dat;
        prev_lst   = io.sw_lst;
        @(posedge clk);
        #1;
        cyc++;
        if (ld_go) begin
            void'(in_q.pop_front());
            acc_cnt++;
            if (acc_cnt % BEATS == 0) last_acc_cyc = cyc;
        end
    endtask

    // mode 0/1: fixed sw_rdy; mode 2: sw_rdy alternates every cycle.
    task automatic run(input string tag, input int mode, input int limit);
        for (int c = 0; c < limit; c++) begin
            if (in_q.size() == 0 && exp_q.size() == 0) break;
            step((mode == 2) ? c[0] : 1'(mode));
        end
        chk_i({tag, "_drained"}, exp_q.size(), 0);
        chk_i({tag, "_loaded"}, in_q.size(), 0);
    endtask

    initial begin
        rstn = 1'b1; clr = 1'b0; ilv = 1'b0;
        io.ld_vld = 1'b0; io.ld_dat = {DW{1'b0}}; io.sw_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_b("rst_ld_rdy", io.ld_rdy, 1'b0);
        chk_b("rst_sw_vld", io.sw_vld, 1'b0);
        chk("rst_sw_dat", io.sw_dat, {DW{1'b0}});
        chk_b("rst_sw_lst", io.sw_lst, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        rstn = 1'b0;
        #1;
        chk_b("rdy_before_edge", io.ld_rdy, 1'b0);
        @(posedge clk);
        #1;
        chk_b("rdy_after_edge", io.ld_rdy, 1'b1);

        // Interleaved load, free-running output.
        ilv_base = 1'b1;
        push_poly(0, 1'b1);
        run("ilv", 1, 400);
        repeat (2) step(1'b1);
        chk_b("idle_busy", busy, 1'b0);

        // Natural load: sw_vld 2 cycles after the final accepted beat.
        ilv_base = 1'b0;
        first_vld_cyc = -1;
        push_poly(0, 1'b0);
        repeat (5) step(1'b1);
        chk_b("busy_load", busy, 1'b1);
        run("nat", 1, 400);
        chk_i("latency", first_vld_cyc, last_acc_cyc + 2);

        // Back-to-back polynomials: no output bubble across the bank boundary.
        n_out = 0;
        push_poly(0, 1'b0);
        push_poly(2048, 1'b0);
        run("b2b", 1, 800);
        chk_i("b2b_count", n_out, 2 * BEATS);
        chk_i("b2b_span", out_last - out_first, 2 * BEATS - 1);

        // Backpressure: both banks fill, loading stalls, head stays beat 0.
        ilv_base = 1'b1;
        acc_cnt = 0;
        push_poly(4096, 1'b1);
        push_poly(8192, 1'b1);
        push_poly(12288, 1'b1);
        repeat (300) step(1'b0);
        chk_i("bp_accepted", acc_cnt, 2 * BEATS);
        chk_b("bp_ld_rdy", io.ld_rdy, 1'b0);
        chk_b("bp_sw_vld", io.sw_vld, 1'b1);
        chk("bp_head", io.sw_dat, exp_q[0]);
        chk_b("bp_busy", busy, 1'b1);
        run("bp", 1, 1000);

        // Toggling sw_rdy, with ilv wiggling after each first beat.
        ilv_glitch = 1'b1;
        push_poly(20000, 1'b1);
        push_poly(30000, 1'b1);
        run("tog", 2, 2000);
        ilv_glitch = 1'b0;

        // rstn mid-operation: one full bank stalled plus 40 beats in the other.
        ilv_base = 1'b0;
        acc_cnt = 0;
        push_poly(100, 1'b0);
        push_poly(200, 1'b0);
        for (int c = 0; c < 600 && acc_cnt < BEATS + 40; c++) step(1'b0);
        chk_i("pre_rst_acc", acc_cnt, BEATS + 40);
        chk_b("pre_rst_vld", io.sw_vld, 1'b1);
        rstn = 1'b1;
        #1;
        chk_b("arst_ld_rdy", io.ld_rdy, 1'b0);
        chk_b("arst_sw_vld", io.sw_vld, 1'b0);
        chk("arst_sw_dat", io.sw_dat, {DW{1'b0}});
        chk_b("arst_sw_lst", io.sw_lst, 1'b0);
        chk_b("arst_busy", busy, 1'b0);
        in_q.delete(); exp_q.delete(); exp_lst_q.delete();
        prev_stall = 1'b0; acc_cnt = 0; io.ld_vld = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk_b("post_rst_rdy", io.ld_rdy, 1'b1);
        repeat (4) step(1'b1);
        chk_b("post_rst_quiet", io.sw_vld, 1'b0);
        push_poly(300, 1'b0);
        run("post_rst", 1, 400);

        // clr with a full bank stalled and 10 beats in the other; clr beats
        // a simultaneous load beat and output pop.
        ilv_base = 1'b1;
        acc_cnt = 0;
        push_poly(400, 1'b1);
        push_poly(500, 1'b1);
        for (int c = 0; c < 600 && acc_cnt < BEATS + 10; c++) step(1'b0);
        chk_i("pre_clr_acc", acc_cnt, BEATS + 10);
        chk_b("pre_clr_vld", io.sw_vld, 1'b1);
        in_q.delete(); exp_q.delete(); exp_lst_q.delete();
        prev_stall = 1'b0; acc_cnt = 0;
        io.ld_vld = 1'b1;
        io.ld_dat = mk(777, 0);
        io.sw_rdy = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        io.ld_vld = 1'b0;
        chk_b("clr_ld_rdy", io.ld_rdy, 1'b1);
        chk_b("clr_sw_vld", io.sw_vld, 1'b0);
        chk("clr_sw_dat", io.sw_dat, {DW{1'b0}});
        chk_b("clr_sw_lst", io.sw_lst, 1'b0);
        chk_b("clr_busy", busy, 1'b0);
        repeat (4) step(1'b1);
        push_poly(600, 1'b1);
        run("post_clr", 1, 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ntt_stream_reorder.md
Name: ntt_stream_reorder

Overview:
Parametrised ping-pong reorder buffer sitting between the host load stream and the NTT kernel output switch. It accepts polynomial beats of LANES x WORD_W coefficients in either natural or half-interleaved order (low-half beat, then high-half beat). It emits each polynomial in natural coefficient order on a valid/ready stream and flags the final beat. Two banks let one polynomial drain while the next one loads.

Parameters:
LANES, 8, coefficients per beat
WORD_W, 16, bits per coefficient
N, 1024, coefficients per polynomial; power of two; N/LANES even and >= 4
BEATS, N/LANES (derived, not overridable), rows per bank

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  reset, asynchronous, active-high
clr  input  1  synchronous clear of all bank state, counters and output entries
ilv  input  1  order of incoming polynomial: 1 = half-interleaved, 0 = natural
ld_vld  input  1  input beat valid
ld_rdy  output  1  input beat ready
ld_dat  input  LANES*WORD_W  input beat; lane 0 in LSBs
sw_vld  output  1  output beat valid
sw_rdy  input  1  output beat ready
sw_dat  output  LANES*WORD_W  output beat; lane 0 in LSBs
sw_lst  output  1  qualifies final beat (row BEATS-1) of a polynomial
busy  output  1  any bank non-empty or any output entry valid

Behaviour:
- Reset (rstn=1, asynchronous) forces these values: ld_rdy=0, sw_vld=0, sw_dat=0, sw_lst=0, busy=0; both banks EMPTY; write select wsel=0; read select rsel=0; counters 0.
- ld_rdy is registered. It reads 1 from the first clk edge after rstn deasserts.
- Transfer rule: a beat moves when vld and rdy are both 1 at a clk edge. The sender holds vld and data until the beat is accepted. sw_dat and sw_lst stay stable while sw_vld=1 and sw_rdy=0.
- Bank states: EMPTY -> FILLING (first beat accepted) -> FULL (beat BEATS-1 accepted) -> DRAINING (first read issued) -> EMPTY (beat BEATS-1 handed to the output queue).
- ilv is latched per bank on the first accepted beat of that bank. Changes to ilv mid-polynomial are ignored.
- Write row for input beat k (0..BEATS-1):
  - natural order: row = k.
  - interleaved order: row = k/2 for even k; row = BEATS/2 + (k-1)/2 for odd k.
- ld_rdy=1 when bank[wsel] is EMPTY or FILLING. On the last beat, wsel toggles and ld_rdy is re-evaluated against the other bank at the next edge.
- When both banks are FULL or DRAINING, ld_rdy=0.
- Reads issue rows 0..BEATS-1 in order from bank[rsel].
- The RAM has one-cycle read latency. A 2-entry output queue absorbs it. A read issues only when the queue will have room.
- Throughput: with sw_rdy held at 1, the block sustains 1 beat/cycle with no bubbles across the bank boundary.
- Latency: sw_vld rises exactly 2 cycles after the edge that accepts the last input beat of a bank, provided that bank is next in read order and the queue is empty.
- sw_lst=1 on the row BEATS-1 beat only. rsel toggles when that row is issued.
- Simultaneous events: a bank completing its write and the other bank issuing its final read on the same edge both take effect. There is no lost state and no extra stall cycle.
- clr has priority over ld/sw transfers in the same cycle. It behaves like reset, except ld_rdy=1 on the next cycle. Any partial polynomial is discarded.
- Reset mid-operation discards all data. No output beat appears until a full new polynomial has been loaded.
- busy = any bank != EMPTY, or any queue entry valid.

Decomposition:
- Package ntt_io_pkg holds:
  - bank state enum (EMPTY, FILLING, FULL, DRAINING);
  - the function row_map(k, ilv, BEATS);
  - default LANES/WORD_W/N constants.
- Sub-module ntt_bank_ram: simple dual-port RAM, depth 2*BEATS, width LANES*WORD_W, one write port, one registered read port. The bank index is the address MSB.

Test Plan:
- Interleaved load with defaults: beat 2i = words i*8+j, beat 2i+1 = words 512+i*8+j (i=0..63), sw_rdy=1 -> 128 beats out, beat m = words m*8+j; sw_lst only on beat 127.
- Natural load (ilv=0) of words 0..1023 -> identical output. First sw_vld is 2 cycles after the accepting edge of input beat 127.
- Back-to-back: two polynomials (second one = value+2048), ld_vld=1 and sw_rdy=1 throughout -> 256 outputs with no gap; sw_lst on output beats 127 and 255.
- Backpressure: hold sw_rdy=0 while loading 3 polynomials -> ld_rdy drops to 0 after 256 accepted beats. Output holds beat 0 stable. Releasing sw_rdy drains all data in order.
- sw_rdy toggling 1-cycle on/off during drain -> no dropped or duplicated beats; data is stable while stalled.
- rstn=1 pulsed after 40 beats loaded -> all outputs at reset values immediately. A fresh full load then yields a correct polynomial. clr asserted after 10 beats behaves the same, with ld_rdy=1 one cycle later.
